pipe_lane_sequencer: RTL and testbench
======================================

// Module: pipe_lane_sequencer
// PURPOSE
//  Sequences a single PIPE lane between byte-serial link logic (10-bit symbol/cycle) and a
//  DataWidth PIPE word interface. Owns the byte-phase counter and the RX word sample strobe.
//  Also owns TX word assembly and COM-based symbol-lock tracking, so pcieVHost x1 wrappers
//  need no ad-hoc rxcount/shift logic. Runs entirely on pcieclk; pclk is derived externally.
// PARAMETERS
//  DataWidth  64  PIPE word width; 8, 16, 32 or 64 only; NB = DataWidth/8 byte lanes
//  LockCount  4   consecutive same-offset COMs needed to declare lock (1..15)
//  MissLimit  3   consecutive wrong-offset COMs while locked that force relock (1..15)
// PORTS
//  pcieclk        in   1      byte-rate clock
//  nreset         in   1      asynchronous, active-low reset
//  rx_word        in   DW     PIPE RX data, lane 0 = bits [7:0], first on the wire
//  rx_wordk       in   NB     PIPE RX K flags, one per lane
//  rx_byte        out  8      serialized RX byte to link
//  rx_k           out  1      K flag for rx_byte
//  tx_byte        in   8      link output byte
//  tx_k           in   1      K flag for tx_byte
//  tx_word        out  DW     assembled PIPE TX word
//  tx_wordk       out  NB     assembled TX K flags
//  tx_word_vld    out  1      1-cycle pulse: tx_word/tx_wordk updated
//  phase          out  PW     byte phase, PW = max(1,clog2(NB)); 0..NB-1
//  word_strobe    out  1      high when phase==0 (RX word sampled this edge)
//  rx_locked      out  1      COM symbol lock achieved
//  rx_lane_off    out  PW     byte lane holding the locked COM
//  com_err_cnt    out  8      saturating count of wrong-offset COMs while locked
// BEHAVIOUR
//  - Reset: phase=0; all outputs 0; aligner state SEARCH; partial TX word discarded.
//    Async assert, synchronous release on the first pcieclk after deassert.
//  - phase increments each cycle, wraps NB-1 -> 0. DataWidth==8: phase held at 0,
//    word_strobe=1 whenever not in reset.
//  - RX: at phase 0, rx_word/rx_wordk are captured. Lane i of the word captured at cycle t
//    drives rx_byte/rx_k at cycle t+1+i (registered outputs).
//  - TX: tx_byte/tx_k at phase p are stored in lane p. At the edge where phase==NB-1, the
//    full word (including that byte) loads tx_word/tx_wordk and tx_word_vld pulses next cycle.
//  - COM = K-flag set and byte 8'hBC. Detection uses captured words only. With multiple COMs
//    in one word, the lowest lane wins.
//  - Aligner FSM, evaluated on each captured word containing a COM (others: no change):
//      SEARCH: off<=lane, cnt<=1 -> CHECK (LockCount==1: -> LOCKED directly)
//      CHECK : lane==off: cnt++, at cnt==LockCount -> LOCKED; else off<=lane, cnt<=1
//      LOCKED: lane==off: miss<=0; else miss++, com_err_cnt++ (sat 255);
//              miss==MissLimit -> SEARCH, rx_locked<=0, miss<=0
//  - rx_locked=1 only in LOCKED; rx_lane_off valid when locked, else holds last off.
//  - com_err_cnt clears only on reset.
// CONFIGURATION
//  PIPE_SEQ_ELECIDLE_EN defined: adds input elec_idle (1b). While high: rx_byte/rx_k forced 0,
//    aligner forced to SEARCH, rx_locked=0, captures ignored. TX unaffected.
//  Undefined: no port; aligner runs continuously.
// STRUCTURE
//  Package pipe_seq_pkg:
//    - aligner state typedef (SEARCH/CHECK/LOCKED)
//    - COM_SYM = 8'hBC
//    - legal-width check function
//  Sub-module pipe_com_aligner: takes captured word + strobe; outputs rx_locked,
//    rx_lane_off, com_err_cnt. Phase counter and RX/TX datapaths stay in the top module.
// TESTING
//  - Reset, DW=64: no stimulus -> phase cycles 0..7; word_strobe every 8th cycle; outputs 0.
//  - RX ordering: rx_word=64'h0807060504030201, K=0 at phase 0 -> rx_byte 01..08 on
//    cycles t+1..t+8.
//  - TX assembly: tx_byte 0xA0..0xA7 at phases 0..7 -> tx_word=64'hA7A6A5A4A3A2A1A0,
//    tx_word_vld one pulse.
//  - Lock: COM in lane 3 for 4 captured words -> rx_locked=1 after 4th; rx_lane_off=3.
//  - Relock: locked at lane 3, COM in lane 5 for 3 words -> com_err_cnt=3, rx_locked=0;
//    4 more lane-5 COMs -> locked, off=5.
//  - Reset mid-word at phase 4 -> phase=0, no tx_word_vld, aligner SEARCH;
//    DW=8 build passes bytes with latency 1.

Source files
------------

// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the PIPE lane sequencer: aligner states, the COM
// symbol and the legal PIPE word width check.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam int         CNT_W   = 4;

  function automatic bit width_ok(input int dw);
    return (dw == 8) || (dw == 16) || (dw == 32) || (dw == 64);
  endfunction

endpackage

// File: rtl/pipe_com_aligner.sv
// COM-based symbol lock tracker. Evaluates each captured PIPE word; the lowest lane
// holding a COM is compared against the current lock offset.
module pipe_com_aligner
  import pipe_seq_pkg::*;
#(
  parameter  int DataWidth = 64,
  parameter  int LockCount = 4,
  parameter  int MissLimit = 3,
  localparam int NB        = DataWidth / 8,
  localparam int PW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                 pcieclk,
  input  logic                 nreset,
  input  logic                 strobe,
  input  logic                 clear,
  input  logic [DataWidth-1:0] word,
  input  logic [NB-1:0]        wordk,
  output logic                 rx_locked,
  output logic [PW-1:0]        rx_lane_off,
  output logic [7:0]           com_err_cnt
);

  align_state_t     state, state_nxt;
  logic [PW-1:0]    off, off_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] miss, miss_nxt;
  logic [7:0]       err, err_nxt;
  logic             found;
  logic [PW-1:0]    lane;

  // Scan from the top lane down so the lowest COM lane is the last one written.
  always_comb begin
    found = 1'b0;
    lane  = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (wordk[i] && (word[8*i +: 8] == COM_SYM)) begin
        found = 1'b1;
        lane  = PW'(i);
      end
    end
  end

  // NOTE: every output of this block is defaulted to its held value first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    off_nxt   = off;
    cnt_nxt   = cnt;
    miss_nxt  = miss;
    err_nxt   = err;
    if (clear) begin
      state_nxt = SEARCH;
      cnt_nxt   = '0;
      miss_nxt  = '0;
    end else if (strobe && found) begin
      unique case (state)
        SEARCH: begin
          off_nxt   = lane;
          cnt_nxt   = CNT_W'(1);
          state_nxt = (LockCount == 1) ? LOCKED : CHECK;
        end
        CHECK: begin
          if (lane == off) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt_nxt == CNT_W'(LockCount)) state_nxt = LOCKED;
          end else begin
            off_nxt = lane;
            cnt_nxt = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (lane == off) begin
            miss_nxt = '0;
          end else begin
            miss_nxt = miss + CNT_W'(1);
            if (err != 8'hFF) err_nxt = err + 8'd1;
            if (miss_nxt == CNT_W'(MissLimit)) begin
              state_nxt = SEARCH;
              miss_nxt  = '0;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together
  // from values sampled before the edge.
  always_ff @(posedge pcieclk or negedge nreset) begin
    if (!nreset) begin
      state <= SEARCH;
      off   <= '0;
      cnt   <= '0;
      miss  <= '0;
      err   <= '0;
    end else begin
      state <= state_nxt;
      off   <= off_nxt;
      cnt   <= cnt_nxt;
      miss  <= miss_nxt;
      err   <= err_nxt;
    end
  end

  assign rx_locked   = (state == LOCKED);
  assign rx_lane_off = off;
  assign com_err_cnt = err;

endmodule

// File: rtl/pipe_lane_sequencer.sv
// Single PIPE lane sequencer: byte phase counter, RX word serializer, TX word assembler
// and COM aligner. Define PIPE_SEQ_ELECIDLE_EN to add the elec_idle input.
module pipe_lane_sequencer
  import pipe_seq_pkg::*;
#(
  parameter  int DataWidth = 64,
  parameter  int LockCount = 4,
  parameter  int MissLimit = 3,
  localparam int NB        = DataWidth / 8,
  localparam int PW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                 pcieclk,
  input  logic                 nreset,
`ifdef PIPE_SEQ_ELECIDLE_EN
  input  logic                 elec_idle,
`endif
  input  logic [DataWidth-1:0] rx_word,
  input  logic [NB-1:0]        rx_wordk,
  output logic [7:0]           rx_byte,
  output logic                 rx_k,
  input  logic [7:0]           tx_byte,
  input  logic                 tx_k,
  output logic [DataWidth-1:0] tx_word,
  output logic [NB-1:0]        tx_wordk,
  output logic                 tx_word_vld,
  output logic [PW-1:0]        phase,
  output logic                 word_strobe,
  output logic                 rx_locked,
  output logic [PW-1:0]        rx_lane_off,
  output logic [7:0]           com_err_cnt
);

  if (!width_ok(DataWidth)) begin : g_bad_width
    $error("pipe_lane_sequencer: DataWidth must be 8, 16, 32 or 64");
  end

  logic                 run;
  logic                 idle;
  logic                 capture;
  logic [DataWidth-1:0] cap;
  logic [NB-1:0]        cap_k;
  logic [7:0]           cap_sel;
  logic                 capk_sel;
  logic [DataWidth-1:0] tx_acc, tx_acc_nxt;
  logic [NB-1:0]        tx_acck, tx_acck_nxt;

`ifdef PIPE_SEQ_ELECIDLE_EN
  assign idle = elec_idle;
`else
  assign idle = 1'b0;
`endif

  // run holds the counter at phase 0 until the first edge after reset release.
  always_ff @(posedge pcieclk or negedge nreset) begin
    if (!nreset) begin
      run   <= 1'b0;
      phase <= '0;
    end else begin
      run <= 1'b1;
      if (run) phase <= (phase == PW'(NB - 1)) ? '0 : phase + PW'(1);
    end
  end

  assign word_strobe = run && (phase == '0);
  assign capture     = word_strobe && !idle;

  always_comb begin
    cap_sel  = '0;
    capk_sel = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (phase == PW'(i)) begin
        cap_sel  = cap[8*i +: 8];
        capk_sel = cap_k[i];
      end
    end
  end

  // Lane 0 goes straight out on the capture edge; later lanes come from the held word.
  always_ff @(posedge pcieclk or negedge nreset) begin
    if (!nreset) begin
      cap     <= '0;
      cap_k   <= '0;
      rx_byte <= '0;
      rx_k    <= 1'b0;
    end else if (idle) begin
      rx_byte <= '0;
      rx_k    <= 1'b0;
    end else if (capture) begin
      cap     <= rx_word;
      cap_k   <= rx_wordk;
      rx_byte <= rx_word[7:0];
      rx_k    <= rx_wordk[0];
    end else begin
      rx_byte <= cap_sel;
      rx_k    <= capk_sel;
    end
  end

  always_comb begin
    tx_acc_nxt  = tx_acc;
    tx_acck_nxt = tx_acck;
    for (int i = 0; i < NB; i++) begin
      if (phase == PW'(i)) begin
        tx_acc_nxt[8*i +: 8] = tx_byte;
        tx_acck_nxt[i]       = tx_k;
      end
    end
  end

  always_ff @(posedge pcieclk or negedge nreset) begin
    if (!nreset) begin
      tx_acc      <= '0;
      tx_acck     <= '0;
      tx_word     <= '0;
      tx_wordk    <= '0;
      tx_word_vld <= 1'b0;
    end else begin
      tx_word_vld <= 1'b0;
      if (run) begin
        tx_acc  <= tx_acc_nxt;
        tx_acck <= tx_acck_nxt;
        if (phase == PW'(NB - 1)) begin
          tx_word     <= tx_acc_nxt;
          tx_wordk    <= tx_acck_nxt;
          tx_word_vld <= 1'b1;
        end
      end
    end
  end

  pipe_com_aligner #(
    .DataWidth(DataWidth),
    .LockCount(LockCount),
    .MissLimit(MissLimit)
  ) u_aligner (
    .pcieclk    (pcieclk),
    .nreset     (nreset),
    .strobe     (capture),
    .clear      (idle),
    .word       (rx_word),
    .wordk      (rx_wordk),
    .rx_locked  (rx_locked),
    .rx_lane_off(rx_lane_off),
    .com_err_cnt(com_err_cnt)
  );

endmodule

// File: tb/tb_pipe_lane_sequencer.sv
// Directed self-checking bench for pipe_lane_sequencer: a 64-bit lane instance covering
// phase, RX/TX paths, lock/relock and mid-word reset, plus an 8-bit instance.
module tb_pipe_lane_sequencer;

  logic pcieclk = 1'b0;
  logic nreset;
  always #5 pcieclk = ~pcieclk;

`ifdef PIPE_SEQ_ELECIDLE_EN
  logic elec_idle;
`endif

  logic [63:0] rx_word;
  logic [7:0]  rx_wordk;
  logic [7:0]  rx_byte;
  logic        rx_k;
  logic [7:0]  tx_byte;
  logic        tx_k;
  logic [63:0] tx_word;
  logic [7:0]  tx_wordk;
  logic        tx_word_vld;
  logic [2:0]  phase;
  logic        word_strobe;
  logic        rx_locked;
  logic [2:0]  rx_lane_off;
  logic [7:0]  com_err_cnt;

  logic [7:0]  rx8_word;
  logic [0:0]  rx8_wordk;
  logic [7:0]  rx8_byte;
  logic        rx8_k;
  logic [7:0]  tx8_byte;
  logic        tx8_k;
  logic [7:0]  tx8_word;
  logic [0:0]  tx8_wordk;
  logic        tx8_word_vld;
  logic [0:0]  phase8;
  logic        word_strobe8;
  logic        rx8_locked;
  logic [0:0]  rx8_lane_off;
  logic [7:0]  com_err_cnt8;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_lane_sequencer #(.DataWidth(64)) dut (
    .pcieclk    (pcieclk),
    .nreset     (nreset),
`ifdef PIPE_SEQ_ELECIDLE_EN
    .elec_idle  (elec_idle),
`endif
    .rx_word    (rx_word),
    .rx_wordk   (rx_wordk),
    .rx_byte    (rx_byte),
    .rx_k       (rx_k),
    .tx_byte    (tx_byte),
    .tx_k       (tx_k),
    .tx_word    (tx_word),
    .tx_wordk   (tx_wordk),
    .tx_word_vld(tx_word_vld),
    .phase      (phase),
    .word_strobe(word_strobe),
    .rx_locked  (rx_locked),
    .rx_lane_off(rx_lane_off),
    .com_err_cnt(com_err_cnt)
  );

  pipe_lane_sequencer #(.DataWidth(8)) dut8 (
    .pcieclk    (pcieclk),
    .nreset     (nreset),
`ifdef PIPE_SEQ_ELECIDLE_EN
    .elec_idle  (elec_idle),
`endif
    .rx_word    (rx8_word),
    .rx_wordk   (rx8_wordk),
    .rx_byte    (rx8_byte),
    .rx_k       (rx8_k),
    .tx_byte    (tx8_byte),
    .tx_k       (tx8_k),
    .tx_word    (tx8_word),
    .tx_wordk   (tx8_wordk),
    .tx_word_vld(tx8_word_vld),
    .phase      (phase8),
    .word_strobe(word_strobe8),
    .rx_locked  (rx8_locked),
    .rx_lane_off(rx8_lane_off),
    .com_err_cnt(com_err_cnt8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pcieclk);
    #1;
  endtask

  // Presents one word during a phase-0 cycle, then idles the RX inputs to the next word.
  task automatic send_word(input logic [63:0] w, input logic [7:0] k);
    rx_word  = w;
    rx_wordk = k;
    tick();
    rx_word  = '0;
    rx_wordk = '0;
    repeat (7) tick();
  endtask

  localparam logic [63:0] COM_L2 = 64'h0000_0000_00BC_0000;
  localparam logic [63:0] COM_L3 = 64'h0000_0000_BC00_0000;
  localparam logic [63:0] COM_L5 = 64'h0000_BC00_0000_0000;
  localparam logic [63:0] BC_L1  = 64'h0000_0000_0000_BC00;

  initial begin
    int vld_cnt;
    nreset   = 1'b0;
`ifdef PIPE_SEQ_ELECIDLE_EN
    elec_idle = 1'b0;
`endif
    rx_word  = '0;
    rx_wordk = '0;
    tx_byte  = '0;
    tx_k     = 1'b0;
    rx8_word = '0;
    rx8_wordk = '0;
    tx8_byte = '0;
    tx8_k    = 1'b0;

    #12;
    check("reset_phase", phase, 0);
    check("reset_strobe", word_strobe, 0);
    check("reset_rx_byte", rx_byte, 0);
    check("reset_tx_word", tx_word, 0);
    check("reset_tx_vld", tx_word_vld, 0);
    check("reset_locked", rx_locked, 0);
    check("reset_err", com_err_cnt, 0);

    tick();
    nreset = 1'b1;
    tick();

    // Idle sweep: two full words with no stimulus.
    for (int k = 0; k < 16; k++) begin
      check($sformatf("idle_phase_%0d", k), phase, 64'(k % 8));
      check($sformatf("idle_strobe_%0d", k), word_strobe, 64'((k % 8) == 0));
      if (k == 7) begin
        check("idle_rx_byte", rx_byte, 0);
        check("idle_tx_word", tx_word, 0);
        check("idle_locked", rx_locked, 0);
      end
      tick();
    end

    // RX ordering, starting in a phase-0 cycle.
    rx_word  = 64'h0807_0605_0403_0201;
    rx_wordk = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      rx_word = '0;
      check($sformatf("rx_byte_lane%0d", i), rx_byte, 64'(i + 1));
      check($sformatf("rx_k_lane%0d", i), rx_k, 0);
    end
    check("rx_end_phase", phase, 0);

    // TX assembly over one word.
    vld_cnt = 0;
    for (int p = 0; p < 8; p++) begin
      tx_byte = 8'hA0 + 8'(p);
      tx_k    = (p == 2);
      tick();
      vld_cnt += int'(tx_word_vld);
    end
    check("tx_word", tx_word, 64'hA7A6_A5A4_A3A2_A1A0);
    check("tx_wordk", tx_wordk, 64'h04);
    check("tx_vld_last", tx_word_vld, 1);
    check("tx_vld_count", 64'(vld_cnt), 1);
    tx_byte = '0;
    tx_k    = 1'b0;
    tick();
    check("tx_vld_drop", tx_word_vld, 0);
    repeat (7) tick();

    // Lock on lane 3.
    for (int n = 1; n <= 4; n++) begin
      send_word(COM_L3, 8'h08);
      check($sformatf("lock_l3_locked_%0d", n), rx_locked, 64'(n == 4));
    end
    check("lock_l3_off", rx_lane_off, 3);
    check("lock_l3_err", com_err_cnt, 0);

    // Relock on lane 5.
    for (int n = 1; n <= 3; n++) begin
      send_word(COM_L5, 8'h20);
      check($sformatf("miss_err_%0d", n), com_err_cnt, 64'(n));
      check($sformatf("miss_locked_%0d", n), rx_locked, 64'(n < 3));
    end
    check("miss_off_held", rx_lane_off, 3);
    for (int n = 1; n <= 4; n++) begin
      send_word(COM_L5, 8'h20);
      check($sformatf("relock_locked_%0d", n), rx_locked, 64'(n == 4));
    end
    check("relock_off", rx_lane_off, 5);
    check("relock_err", com_err_cnt, 3);

    // Non-K 0xBC is not a COM; with two COMs the lowest lane wins.
    send_word(COM_L5 | BC_L1, 8'h20);
    check("nonk_err", com_err_cnt, 3);
    send_word(COM_L5 | COM_L2, 8'h24);
    check("lowlane_err", com_err_cnt, 4);
    check("lowlane_locked", rx_locked, 1);
    check("lowlane_off", rx_lane_off, 5);

    // Reset in the middle of a word.
    for (int p = 0; p < 4; p++) begin
      tx_byte = 8'hD0 + 8'(p);
      tick();
    end
    check("pre_reset_phase", phase, 4);
    nreset = 1'b0;
    #1;
    check("midrst_phase", phase, 0);
    check("midrst_strobe", word_strobe, 0);
    check("midrst_locked", rx_locked, 0);
    check("midrst_off", rx_lane_off, 0);
    check("midrst_err", com_err_cnt, 0);
    check("midrst_tx_word", tx_word, 0);
    tx_byte = '0;
    tick();
    nreset = 1'b1;
    tick();
    check("post_rst_phase", phase, 0);
    vld_cnt = 0;
    for (int p = 0; p < 8; p++) begin
      tx_byte = 8'hC0 + 8'(p);
      tick();
      if (p < 7) vld_cnt += int'(tx_word_vld);
    end
    check("post_rst_no_vld", 64'(vld_cnt), 0);
    check("post_rst_vld", tx_word_vld, 1);
    check("post_rst_tx_word", tx_word, 64'hC7C6_C5C4_C3C2_C1C0);
    check("post_rst_locked", rx_locked, 0);
    tx_byte = '0;

    // 8-bit instance: every cycle is a word, latency of one.
    rx8_word  = 8'h5A;
    rx8_wordk = 1'b0;
    tx8_byte  = 8'h77;
    tx8_k     = 1'b1;
    tick();
    check("dw8_rx_byte_a", rx8_byte, 64'h5A);
    check("dw8_rx_k_a", rx8_k, 0);
    check("dw8_tx_word_a", tx8_word, 64'h77);
    check("dw8_tx_wordk_a", tx8_wordk, 1);
    check("dw8_vld_a", tx8_word_vld, 1);
    check("dw8_phase", phase8, 0);
    check("dw8_strobe", word_strobe8, 1);
    rx8_word  = 8'h3C;
    rx8_wordk = 1'b1;
    tx8_byte  = 8'h12;
    tx8_k     = 1'b0;
    tick();
    check("dw8_rx_byte_b", rx8_byte, 64'h3C);
    check("dw8_rx_k_b", rx8_k, 1);
    check("dw8_tx_word_b", tx8_word, 64'h12);
    check("dw8_vld_b", tx8_word_vld, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
